// File: rtl/fir_tdf_prog_if.sv
// Sample, coefficient and result signals of the programmable transposed-form FIR.
// The source side (master) drives samples, flushes and coefficient writes.
// The filter (slave) returns registered results and the sticky saturation flag.
interface fir_tdf_prog_if #(
    parameter int TAPS   = 8,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic                     clr;
    logic                     in_valid;
    logic signed [DATA_W-1:0] Xin;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  Yout;
    logic                     ovf;

    modport master (
        output clr,
        output in_valid,
        output Xin,
        output coef_we,
        output coef_addr,
        output coef_data,
        input  out_valid,
        input  Yout,
        input  ovf
    );

    modport slave (
        input  clr,
        input  in_valid,
        input  Xin,
        input  coef_we,
        input  coef_addr,
        input  coef_data,
        output out_valid,
        output Yout,
        output ovf
    );
endinterface

// File: rtl/fir_tdf_prog.sv
// Programmable-coefficient transposed-direct-form FIR filter.
// y[n] = sum C[i]*x[n-i], C[0] weights the newest sample.
// Each accepted sample updates the partial-sum chain Q[1..TAPS-1]; the
// final sum is rounded (half up), shifted, saturated and registered.
// Coefficients can be rewritten at run time; a write on the same edge as
// a sample only takes effect from the following edge.
module fir_tdf_prog #(
    parameter int TAPS      = 8,
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0
) (
    input logic           Clk,
    input logic           Rst,
    fir_tdf_prog_if.slave bus
);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
    localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1;
    // One guard bit so the rounding bias can never wrap the accumulator.
    localparam int RW    = ACC_W + 1;
    // Wide enough to compare against the output range whichever is larger.
    localparam int EXT_W = RW + OUT_W;

    localparam logic signed [OUT_W-1:0] Y_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] Y_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [COEF_W-1:0] coef_reg  [TAPS];
    logic [TAPS-1:0]          coef_hit;
    logic signed [ACC_W-1:0]  prod      [TAPS];
    logic signed [ACC_W-1:0]  q_reg     [1:TAPS-1];
    logic signed [ACC_W-1:0]  q_next    [1:TAPS-1];
    logic signed [ACC_W-1:0]  acc;
    logic signed [RW-1:0]     scaled;
    logic signed [EXT_W-1:0]  scaled_ext;
    logic signed [OUT_W-1:0]  y_next;
    logic                     sat_next;
    logic signed [OUT_W-1:0]  yout_reg;
    logic                     out_valid_reg;
    logic                     ovf_reg;

    // Per-tap write decode and product. Addresses >= TAPS match no tap, so
    // such writes fall away without an explicit range check.
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            assign coef_hit[gi] = bus.coef_we && (bus.coef_addr == AW'(gi));
            assign prod[gi]     = ACC_W'(coef_reg[gi]) * ACC_W'(bus.Xin);
        end
    endgenerate

    // Next value of each partial sum: the last stage starts a fresh sum,
    // every other stage adds its product to the stage above it.
    generate
        for (genvar gi = 1; gi < TAPS; gi++) begin : g_q
            if (gi == TAPS - 1) begin : g_last
                assign q_next[gi] = prod[gi];
            end else begin : g_mid
                assign q_next[gi] = q_reg[gi+1] + prod[gi];
            end
        end
    endgenerate

    assign acc = q_reg[1] + prod[0];

    // Round half up before the arithmetic shift; no bias when not shifting.
    generate
        if (OUT_SHIFT > 0) begin : g_round
            localparam logic signed [RW-1:0] RND = {{(RW-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
            assign scaled = (RW'(acc) + RND) >>> OUT_SHIFT;
        end else begin : g_noround
            assign scaled = RW'(acc);
        end
    endgenerate

    // Clamp the scaled sum into the signed output range and flag any clamp.
    always_comb begin
        scaled_ext = EXT_W'(scaled);
        y_next     = scaled_ext[OUT_W-1:0];
        sat_next   = 1'b0;
        if (scaled_ext > EXT_W'(Y_MAX)) begin
            y_next   = Y_MAX;
            sat_next = 1'b1;
        end else if (scaled_ext < EXT_W'(Y_MIN)) begin
            y_next   = Y_MIN;
            sat_next = 1'b1;
        end
    end

    // Coefficient bank: written independently of flush, cleared only by reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                if (coef_hit[i]) begin
                    coef_reg[i] <= bus.coef_data;
                end
            end
        end
    end

    // Partial-sum chain: advances only on accepted samples, flush wins.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 1; i < TAPS; i++) begin
                q_reg[i] <= '0;
            end
        end else if (bus.clr) begin
            for (int i = 1; i < TAPS; i++) begin
                q_reg[i] <= '0;
            end
        end else if (bus.in_valid) begin
            for (int i = 1; i < TAPS; i++) begin
                q_reg[i] <= q_next[i];
            end
        end
    end

    // Result register, one-cycle valid pulse and sticky saturation flag.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            yout_reg      <= '0;
            out_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (bus.clr) begin
            yout_reg      <= '0;
            out_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                yout_reg <= y_next;
                if (sat_next) begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.Yout      = yout_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_fir_tdf_prog.sv
// Scoreboard bench for fir_tdf_prog: two filters (no shift and OUT_SHIFT=2)
// share one stimulus stream; expected results are queued as samples are
// issued and a negedge monitor pops and compares them on every out_valid.
module tb_fir_tdf_prog;
    localparam int TAPS   = 4;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int OUT_W  = 16;
    localparam int AW     = $clog2(TAPS);

    logic Clk = 1'b0;
    logic Rst;
    logic clr;
    logic in_valid;
    logic coef_we;
    logic signed [DATA_W-1:0] xin;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;

    int total  = 0;
    int passed = 0;

    typedef struct {
        string tag;
        int    e0;
        int    e1;
        bit    c1;
    } exp_t;
    exp_t sb[$];

    fir_tdf_prog_if #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) if0 ();
    fir_tdf_prog_if #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) if1 ();

    assign if0.clr       = clr;
    assign if0.in_valid  = in_valid;
    assign if0.Xin       = xin;
    assign if0.coef_we   = coef_we;
    assign if0.coef_addr = coef_addr;
    assign if0.coef_data = coef_data;
    assign if1.clr       = clr;
    assign if1.in_valid  = in_valid;
    assign if1.Xin       = xin;
    assign if1.coef_we   = coef_we;
    assign if1.coef_addr = coef_addr;
    assign if1.coef_data = coef_data;

    fir_tdf_prog #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .OUT_SHIFT(0)) dut0 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (if0.slave)
    );

    fir_tdf_prog #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .OUT_SHIFT(2)) dut1 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (if1.slave)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string nm, input longint act, input longint exp_v);
        total++;
        if (act == exp_v) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    // One cycle of stimulus, applied at a falling edge.
    task automatic cyc(input bit iv, input int x, input bit we, input int a, input int d, input bit c);
        in_valid  = iv;
        xin       = DATA_W'(x);
        coef_we   = we;
        coef_addr = AW'(a);
        coef_data = COEF_W'(d);
        clr       = c;
        @(negedge Clk);
    endtask

    task automatic smp(input string tag, input int x, input int e0, input bit c1, input int e1);
        sb.push_back('{tag, e0, e1, c1});
        cyc(1'b1, x, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic wr(input int a, input int d);
        cyc(1'b0, 0, 1'b1, a, d, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    // Monitor: every out_valid must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge Clk);
            if (!Rst && if0.out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.tag, "_y"}, if0.Yout, e.e0);
                    $display("out %s: Yout=%0d (exp %0d) Yout_s2=%0d", e.tag, if0.Yout, e.e0, if1.Yout);
                    if (e.c1) begin
                        check({e.tag, "_valid_s2"}, if1.out_valid, 1);
                        check({e.tag, "_y_s2"}, if1.Yout, e.e1);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        Rst = 1'b1; clr = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
        xin = '0; coef_addr = '0; coef_data = '0;
        repeat (2) @(negedge Clk);
        check("rst_yout", if0.Yout, 0);
        check("rst_valid", if0.out_valid, 0);
        check("rst_ovf", if0.ovf, 0);
        check("rst_yout_s2", if1.Yout, 0);
        Rst = 1'b0;

        // Coefficients reset to zero: every output is zero.
        smp("zc0", 1, 0, 1, 0);
        smp("zc1", 50, 0, 1, 0);
        smp("zc2", -7, 0, 1, 0);
        smp("zc3", 127, 0, 1, 0);

        // Impulse with C = {-2, -1, 3, 4}.
        wr(0, -2); wr(1, -1); wr(2, 3); wr(3, 4);
        smp("imp0", 1, -2, 1, 0);
        smp("imp1", 0, -1, 1, 0);
        smp("imp2", 0, 3, 1, 1);
        smp("imp3", 0, 4, 1, 1);
        smp("imp4", 0, 0, 1, 0);

        // Step of 10 with 3-cycle stalls between samples.
        smp("stp0", 10, -20, 1, -5);
        idle(3);
        check("gap0_hold", if0.Yout, -20);
        check("gap0_valid", if0.out_valid, 0);
        smp("stp1", 10, -30, 1, -7);
        idle(3);
        check("gap1_hold", if0.Yout, -30);
        smp("stp2", 10, 0, 1, 0);
        idle(3);
        smp("stp3", 10, 40, 1, 10);
        idle(1);
        check("gap3_hold", if0.Yout, 40);

        // Positive saturation; flush shares its edge with the C[0] write.
        cyc(1'b0, 0, 1'b1, 0, 127, 1'b1);
        check("clr_yout", if0.Yout, 0);
        check("clr_valid", if0.out_valid, 0);
        wr(1, 127); wr(2, 127); wr(3, 127);
        smp("sat0", 127, 16129, 1, 4032);
        smp("sat1", 127, 32258, 1, 8065);
        check("ovf_pre", if0.ovf, 0);
        smp("sat2", 127, 32767, 1, 12097);
        check("ovf_set", if0.ovf, 1);
        smp("sat3", 127, 32767, 1, 16129);
        in_valid = 1'b0;
        idle(1);
        check("ovf_sticky", if0.ovf, 1);

        // Negative saturation after a flush.
        cyc(1'b0, 0, 1'b0, 0, 0, 1'b1);
        check("clr_ovf", if0.ovf, 0);
        smp("neg0", -128, -16256, 1, -4064);
        smp("neg1", -128, -32512, 1, -8128);
        smp("neg2", -128, -32768, 1, -12192);
        check("ovf_neg", if0.ovf, 1);
        smp("neg3", -128, -32768, 1, -16256);

        // Rounding with C = {6, 0, 0, 0}.
        cyc(1'b0, 0, 1'b1, 0, 6, 1'b1);
        wr(1, 0); wr(2, 0); wr(3, 0);
        smp("rnd0", 1, 6, 1, 2);
        smp("rnd1", -1, -6, 1, -1);
        smp("rnd2", 2, 12, 1, 3);
        smp("rnd3", 7, 42, 1, 11);

        // Coefficient write colliding with a sample.
        wr(0, -2); wr(1, -1); wr(2, 3); wr(3, 4);
        cyc(1'b0, 0, 1'b0, 0, 0, 1'b1);
        sb.push_back('{"col0", -2, 0, 1'b1});
        cyc(1'b1, 1, 1'b1, 0, 5, 1'b0);
        smp("col1", 1, 4, 1, 1);

        // Flush mid-stream; the sample on the flush edge is dropped.
        smp("cm0", 2, 12, 1, 3);
        smp("cm1", 3, 20, 1, 5);
        cyc(1'b1, 100, 1'b0, 0, 0, 1'b1);
        check("clr2_yout", if0.Yout, 0);
        check("clr2_valid", if0.out_valid, 0);
        smp("cm2", 3, 15, 1, 4);

        // Asynchronous reset between edges.
        smp("ar0", 1, 2, 1, 1);
        in_valid = 1'b0;
        check("ar_pre_valid", if0.out_valid, 1);
        check("ar_pre_y", if0.Yout, 2);
        #2;
        Rst = 1'b1;
        #1;
        check("ar_yout", if0.Yout, 0);
        check("ar_valid", if0.out_valid, 0);
        check("ar_ovf", if0.ovf, 0);
        check("ar_yout_s2", if1.Yout, 0);
        @(negedge Clk);
        Rst = 1'b0;

        // Coefficients were wiped by reset.
        smp("rz0", 1, 0, 1, 0);
        smp("rz1", -128, 0, 1, 0);
        smp("rz2", 99, 0, 1, 0);
        smp("rz3", 0, 0, 1, 0);
        idle(2);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge Clk);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
